regfile_write_seq: RTL and testbench

REGFILE_WRITE_SEQ -- requirements
Module: regfile_write_seq

---
 rtl/regfile_write_seq_pkg.sv | 26 ++
 rtl/regfile_write_seq_addr_gen.sv | 50 +++++
 rtl/regfile_write_seq.sv | 150 +++++++++++++++
 tb/tb_regfile_write_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_seq_pkg.sv
// Shared state encoding and address-wrap helpers for regfile_write_seq.
package regfile_write_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
  localparam state_t ST_FILL   = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  localparam int unsigned ADDR_STEP = 1;

  // Next address inside the legal window [lo, hi]; stepping past hi lands on lo.
  function automatic int unsigned wrap_inc(input int unsigned a,
                                           input int unsigned lo,
                                           input int unsigned hi);
    return (a >= hi) ? lo : a + ADDR_STEP;
  endfunction

  function automatic logic in_range(input int unsigned a,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/regfile_write_seq_addr_gen.sv
// Burst address and remaining-count generator: load on command, step per write,
// wrap hi->lo, last flag when the current write is the final one.
module regfile_write_seq_addr_gen
  import regfile_write_seq_pkg::*;
#(
  parameter int unsigned addr_width = 1,
  parameter int unsigned lo         = 0,
  parameter int unsigned hi         = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [addr_width-1:0] base,
  input  logic [addr_width-1:0] len,
  output logic [addr_width-1:0] addr,
  output logic                  last
);

  localparam logic [addr_width-1:0] ONE = 1;

  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width-1:0] cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = base;
      cnt_d  = len;
    end else if (step) begin
      addr_d = addr_width'(wrap_inc(32'(addr_q), lo, hi));
      cnt_d  = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == ONE);

endmodule

// File: rtl/regfile_write_seq.sv
// Register-file burst write sequencer (stream or fill mode).
// Fill mode is built only when RFSEQ_FILL_EN is defined; otherwise every command streams.
module regfile_write_seq
  import regfile_write_seq_pkg::*;
#(
  parameter int unsigned addr_width = 1,
  parameter int unsigned data_width = 1,
  parameter int unsigned lo         = 0,
  parameter int unsigned hi         = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [addr_width-1:0] CMD_BASE,
  input  logic [addr_width-1:0] CMD_LEN,
  input  logic                  CMD_FILL,
  input  logic [data_width-1:0] CMD_FILL_DATA,
  input  logic                  DAT_VALID,
  output logic                  DAT_READY,
  input  logic [data_width-1:0] DAT_IN,
  output logic [addr_width-1:0] ADDR_IN,
  output logic [data_width-1:0] D_IN,
  output logic                  WE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [addr_width-1:0] addr_in_q, addr_in_d;
  logic [data_width-1:0] d_in_q, d_in_d;
  logic                  ag_load, ag_step, ag_last;
  logic [addr_width-1:0] ag_addr;
  logic                  cmd_fill_sel;

`ifdef RFSEQ_FILL_EN
  logic [data_width-1:0] fill_data_q, fill_data_d;
  assign cmd_fill_sel = CMD_FILL;
`else
  logic unused_fill;
  assign unused_fill  = ^{CMD_FILL, CMD_FILL_DATA};
  assign cmd_fill_sel = 1'b0;
`endif

  regfile_write_seq_addr_gen #(
    .addr_width(addr_width),
    .lo        (lo),
    .hi        (hi)
  ) u_addr_gen (
    .clk  (CLK),
    .rst_n(RST_N),
    .load (ag_load),
    .step (ag_step),
    .base (CMD_BASE),
    .len  (CMD_LEN),
    .addr (ag_addr),
    .last (ag_last)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = 1'b0;
    err_d     = 1'b0;
    addr_in_d = addr_in_q;
    d_in_d    = d_in_q;
    ag_load   = 1'b0;
    ag_step   = 1'b0;
`ifdef RFSEQ_FILL_EN
    fill_data_d = fill_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          if (CMD_LEN == '0) begin
            state_d = ST_FINISH;
          end else if (!in_range(32'(CMD_BASE), lo, hi)) begin
            err_d = 1'b1;
          end else begin
            ag_load = 1'b1;
            state_d = cmd_fill_sel ? ST_FILL : ST_STREAM;
`ifdef RFSEQ_FILL_EN
            fill_data_d = CMD_FILL_DATA;
`endif
          end
        end
      end
      ST_STREAM: begin
        if (DAT_VALID) begin
          we_d      = 1'b1;
          addr_in_d = ag_addr;
          d_in_d    = DAT_IN;
          ag_step   = 1'b1;
          if (ag_last) state_d = ST_FINISH;
        end
      end
`ifdef RFSEQ_FILL_EN
      ST_FILL: begin
        we_d      = 1'b1;
        addr_in_d = ag_addr;
        d_in_d    = fill_data_q;
        ag_step   = 1'b1;
        if (ag_last) state_d = ST_FINISH;
      end
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // DONE is registered on the way into FINISH so it is high while FINISH is held.
    done_d = (state_d == ST_FINISH) && (state_q != ST_FINISH);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_in_q <= '0;
      d_in_q    <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      done_q    <= done_d;
      err_q     <= err_d;
      addr_in_q <= addr_in_d;
      d_in_q    <= d_in_d;
    end
  end

`ifdef RFSEQ_FILL_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) fill_data_q <= '0;
    else        fill_data_q <= fill_data_d;
  end
`endif

  assign CMD_READY = (state_q == ST_IDLE);
  assign DAT_READY = (state_q == ST_STREAM);
  assign BUSY      = (state_q != ST_IDLE);
  assign WE        = we_q;
  assign ADDR_IN   = addr_in_q;
  assign D_IN      = d_in_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_regfile_write_seq.sv
// Scoreboard bench for regfile_write_seq: dut 0 uses window 0..15, dut 1 uses 4..7.
module tb_regfile_write_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic [1:0] cmd_valid, cmd_fill, dat_valid;
  logic [3:0] cmd_base[2], cmd_len[2];
  logic [7:0] cmd_fd[2], dat_in[2];
  logic [1:0] cmd_ready, dat_ready, we, busy, done, err;
  logic [3:0] addr_o[2];
  logic [7:0] dout[2];

  typedef struct {
    int         dut;
    int         kind;   // 0 write, 1 done, 2 err
    logic [3:0] a;
    logic [7:0] v;
    int         cyc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_write_seq #(.addr_width(4), .data_width(8), .lo(0), .hi(15)) u_main (
    .CLK(clk), .RST_N(rst_n),
    .CMD_VALID(cmd_valid[0]), .CMD_READY(cmd_ready[0]), .CMD_BASE(cmd_base[0]),
    .CMD_LEN(cmd_len[0]), .CMD_FILL(cmd_fill[0]), .CMD_FILL_DATA(cmd_fd[0]),
    .DAT_VALID(dat_valid[0]), .DAT_READY(dat_ready[0]), .DAT_IN(dat_in[0]),
    .ADDR_IN(addr_o[0]), .D_IN(dout[0]), .WE(we[0]), .BUSY(busy[0]),
    .DONE(done[0]), .ERR(err[0])
  );

  regfile_write_seq #(.addr_width(4), .data_width(8), .lo(4), .hi(7)) u_win (
    .CLK(clk), .RST_N(rst_n),
    .CMD_VALID(cmd_valid[1]), .CMD_READY(cmd_ready[1]), .CMD_BASE(cmd_base[1]),
    .CMD_LEN(cmd_len[1]), .CMD_FILL(cmd_fill[1]), .CMD_FILL_DATA(cmd_fd[1]),
    .DAT_VALID(dat_valid[1]), .DAT_READY(dat_ready[1]), .DAT_IN(dat_in[1]),
    .ADDR_IN(addr_o[1]), .D_IN(dout[1]), .WE(we[1]), .BUSY(busy[1]),
    .DONE(done[1]), .ERR(err[1])
  );

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic expect_evt(input int d, input int k, input int a, input int v, input int c);
    exp_t e;
    e.dut = d; e.kind = k; e.a = 4'(a); e.v = 8'(v); e.cyc = c;
    q.push_back(e);
  endtask

  task automatic chk_evt(input int d, input int k, input logic [3:0] a, input logic [7:0] v);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_evt: dut=%0d kind=%0d addr=%0h data=%0h cyc=%0d, want none",
               d, k, a, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.dut != d || e.kind != k || e.cyc != cyc ||
          (k == 0 && (e.a !== a || e.v !== v))) begin
        bad++;
        $display("FAIL evt: got dut=%0d kind=%0d addr=%0h data=%0h cyc=%0d, want dut=%0d kind=%0d addr=%0h data=%0h cyc=%0d",
                 d, k, a, v, cyc, e.dut, e.kind, e.a, e.v, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d])   chk_evt(d, 0, addr_o[d], dout[d]);
      if (done[d]) chk_evt(d, 1, 4'h0, 8'h00);
      if (err[d])  chk_evt(d, 2, 4'h0, 8'h00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input int d, input int b, input int l, input logic f, input int fd);
    check("cmd_ready_idle", int'(cmd_ready[d]), 1);
    cmd_valid[d] = 1'b1;
    cmd_base[d]  = 4'(b);
    cmd_len[d]   = 4'(l);
    cmd_fill[d]  = f;
    cmd_fd[d]    = 8'(fd);
    tick();
    cmd_valid[d] = 1'b0;
  endtask

  task automatic beat(input int d, input int a, input int v, input bit last);
    dat_valid[d] = 1'b1;
    dat_in[d]    = 8'(v);
    expect_evt(d, 0, a, v, cyc + 1);
    if (last) expect_evt(d, 1, 0, 0, cyc + 1);
    tick();
    dat_valid[d] = 1'b0;
  endtask

  logic [7:0] sdat[3] = '{8'hA1, 8'hB2, 8'hC3};

  initial begin
    cmd_valid = '0; cmd_fill = '0; dat_valid = '0;
    for (int d = 0; d < 2; d++) begin
      cmd_base[d] = '0; cmd_len[d] = '0; cmd_fd[d] = '0; dat_in[d] = '0;
    end
    #2;
    check("rst_we", int'(we[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_cmd_ready", int'(cmd_ready[0]), 1);
    check("rst_addr", int'(addr_o[0]), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // stream burst base 2, three back-to-back beats
    drive_cmd(0, 2, 3, 1'b0, 0);
    check("busy_stream", int'(busy[0]), 1);
    check("cmd_ready_busy", int'(cmd_ready[0]), 0);
    check("dat_ready_stream", int'(dat_ready[0]), 1);
    for (int i = 0; i < 3; i++) beat(0, 2 + i, sdat[i], i == 2);
    tick(); tick();

    // zero-length command: DONE one cycle after acceptance, no write
    expect_evt(0, 1, 0, 0, cyc + 1);
    drive_cmd(0, 5, 0, 1'b0, 0);
    tick(); tick();
    check("busy_after_len0", int'(busy[0]), 0);

`ifdef RFSEQ_FILL_EN
    // fill burst wrapping 14,15,0,1; stray DAT_VALID must be ignored
    for (int i = 0; i < 4; i++) expect_evt(0, 0, (14 + i) % 16, 8'h05, cyc + 2 + i);
    expect_evt(0, 1, 0, 0, cyc + 5);
    drive_cmd(0, 14, 4, 1'b1, 8'h05);
    dat_valid[0] = 1'b1; dat_in[0] = 8'hEE;
    check("dat_ready_fill", int'(dat_ready[0]), 0);
    for (int i = 0; i < 5; i++) tick();
    dat_valid[0] = 1'b0;
    tick();
`else
    // fill request ignored: waits for two stream beats
    drive_cmd(0, 9, 2, 1'b1, 8'h77);
    tick(); tick(); tick();
    check("dat_ready_nofill", int'(dat_ready[0]), 1);
    beat(0, 9, 8'h11, 1'b0);
    beat(0, 10, 8'h22, 1'b1);
    tick(); tick();
`endif

    // gapped stream burst wrapping 15 -> 0
    drive_cmd(0, 14, 3, 1'b0, 0);
    beat(0, 14, 8'h31, 1'b0);
    tick();
    beat(0, 15, 8'h32, 1'b0);
    tick(); tick();
    beat(0, 0, 8'h33, 1'b1);
    tick(); tick();

    // window 4..7: out-of-range bases rejected
    expect_evt(1, 2, 0, 0, cyc + 1);
    drive_cmd(1, 2, 3, 1'b0, 0);
    check("err_cmd_ready", int'(cmd_ready[1]), 1);
    check("err_busy", int'(busy[1]), 0);
    tick();
    expect_evt(1, 2, 0, 0, cyc + 1);
    drive_cmd(1, 8, 1, 1'b0, 0);
    tick();

    // window 4..7: stream wraps 7 -> 4
    drive_cmd(1, 6, 3, 1'b0, 0);
    beat(1, 6, 8'h61, 1'b0);
    beat(1, 7, 8'h62, 1'b0);
    beat(1, 4, 8'h63, 1'b1);
    tick(); tick();

    // reset mid-burst after two of four beats
    drive_cmd(0, 3, 4, 1'b0, 0);
    beat(0, 3, 8'h41, 1'b0);
    beat(0, 4, 8'h42, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    dat_valid[0] = 1'b1; dat_in[0] = 8'h99;
    #1;
    check("midrst_we", int'(we[0]), 0);
    check("midrst_done", int'(done[0]), 0);
    check("midrst_err", int'(err[0]), 0);
    check("midrst_busy", int'(busy[0]), 0);
    check("midrst_addr", int'(addr_o[0]), 0);
    check("midrst_data", int'(dout[0]), 0);
    check("midrst_cmd_ready", int'(cmd_ready[0]), 1);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst_busy", int'(busy[0]), 0);
    check("post_rst_cmd_ready", int'(cmd_ready[0]), 1);
    dat_valid[0] = 1'b0;
    tick(); tick();

    check("pending_expected", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
